zbt_point_reader: RTL and testbench

- Reads packed point-cloud records back out of ZBT SRAM, unpacks each into signed x/y/z coordinates, and streams them to the projection/render pipeline over a valid/ready handshake.
- It sits on the read side of the same ZBT bank that the point writer fills. Each record is one 36-bit word.
- It hides the fixed ZBT read latency with a credit-limited issue stage and a small output FIFO, so downstream backpressure never drops data.

---
 rtl/zbt_point_reader.sv | 111 +++++++++++
 tb/tb_zbt_point_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_point_reader.sv
// zbt_point_reader: streams packed 36-bit point records out of ZBT SRAM as signed x/y/z over valid/ready.
module zbt_point_reader #(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int COORD_W      = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [18:0]        base_addr,
  input  logic [18:0]        num_points,
  output logic [18:0]        ram_addr,
  output logic               ram_we,
  input  logic [35:0]        ram_data,
  output logic [COORD_W-1:0] point_x,
  output logic [COORD_W-1:0] point_y,
  output logic [COORD_W-1:0] point_z,
  output logic               point_valid,
  input  logic               point_ready,
  output logic               busy,
  output logic               done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int PW = 3 * COORD_W;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t                  state_q, state_d;
  logic [18:0]             base_q, base_d, num_q, num_d, idx_q, idx_d, addr_q, addr_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] vld_q;
  logic [PW-1:0]           fifo_q [FIFO_DEPTH];
  logic [AW-1:0]           wp_q, rp_q;
  logic [CW-1:0]           cnt_q, inflight;
  logic                    issue, push, pop;
  logic [PW-1:0]           head;
  logic [35:PW]            unused_hi;
  assign unused_hi = ram_data[35:PW];
  // credit counts both reads in the latency pipe and words parked in the FIFO, so a push always has room
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
  end
  assign issue = (state_q == ISSUE) && ((inflight + cnt_q) < CW'(FIFO_DEPTH));
  assign push  = vld_q[READ_LATENCY-1];
  assign pop   = point_valid && point_ready;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_points != '0) begin
          base_d  = base_addr;
          num_d   = num_points;
          idx_d   = '0;
          state_d = ISSUE;
        end else done_d = 1'b1;
      end
      ISSUE: if (issue) begin
        addr_d  = base_q + idx_q;
        idx_d   = idx_q + 19'd1;
        state_d = (idx_q == num_q - 19'd1) ? DRAIN : ISSUE;
      end
      DRAIN: if (inflight == '0 && cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      vld_q   <= (vld_q << 1) | READ_LATENCY'(issue);
      wp_q    <= push ? wp_q + 1'b1 : wp_q;
      rp_q    <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= ram_data[PW-1:0];
  end
  assign head        = fifo_q[rp_q];
  assign point_valid = cnt_q != '0;
  assign point_x     = point_valid ? head[PW-1:2*COORD_W] : '0;
  assign point_y     = point_valid ? head[2*COORD_W-1:COORD_W] : '0;
  assign point_z     = point_valid ? head[COORD_W-1:0] : '0;
  assign ram_addr    = addr_q;
  assign ram_we      = 1'b0;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
endmodule

// File: tb/tb_zbt_point_reader.sv
// tb_zbt_point_reader: directed passes against a ZBT read model, scoreboard-checked point stream.
module tb_zbt_point_reader;
  logic        clk = 1'b0;
  logic        reset, start, point_ready;
  logic [18:0] base_addr, num_points, ram_addr;
  logic        ram_we, point_valid, busy, done;
  logic [35:0] ram_data, rd_q;
  logic [9:0]  point_x, point_y, point_z;
  logic [35:0] mem [0:524287];
  logic [29:0] exp_q [$];
  logic [29:0] rx [$];
  logic [18:0] iss_q [$];
  logic [29:0] cur, hold_p;
  logic        stall_p = 1'b0;
  int          vecs = 0, errs = 0, done_n = 0;

  always #5 clk = ~clk;

  zbt_point_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_points(num_points),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .point_x(point_x), .point_y(point_y), .point_z(point_z),
    .point_valid(point_valid), .point_ready(point_ready), .busy(busy), .done(done)
  );

  // ZBT model: data for the address presented after edge N is sampled by the reader at edge N+2
  always @(posedge clk) rd_q <= mem[ram_addr];
  assign ram_data = rd_q;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [9:0] crd(input int k);
    return 10'(k * 50 - 100);
  endfunction

  initial forever begin
    @(negedge clk);
    cur = {point_x, point_y, point_z};
    if (reset) stall_p = 1'b0;
    else begin
      chk("fifo_count_max", 32'(dut.cnt_q <= 4), 1);
      chk("outstanding_max", 32'(($countones(dut.vld_q) + dut.cnt_q) <= 4), 1);
      if (stall_p) begin
        chk("stall_valid", 32'(point_valid), 1);
        chk("stall_hold", 32'(cur), 32'(hold_p));
      end
      if (dut.vld_q[0]) iss_q.push_back(ram_addr);
      if (done) done_n++;
      if (point_valid && point_ready) begin
        rx.push_back(cur);
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_point: got %h expected none", cur);
        end else chk("point", 32'(cur), 32'(exp_q.pop_front()));
      end
      stall_p = point_valid && !point_ready;
      hold_p  = cur;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input logic [18:0] b, input logic [18:0] n);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[19'(int'(b) + i)][29:0]);
    @(posedge clk);
    #1 start = 1'b1; base_addr = b; num_points = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int d0 = done_n;
    int k  = 0;
    while (done_n == d0 && k < lim) begin
      step();
      k++;
    end
    chk({"done_", name}, 32'(done_n != d0), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, k;
    logic [18:0] wl [4];
    reset = 1'b1; start = 1'b0; point_ready = 1'b1; base_addr = '0; num_points = '0;
    repeat (3) step();
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_valid", 32'(point_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_xyz", 32'(cur), 0);
    reset = 1'b0;

    // single point, latency and done timing
    mem[19'h00100] = 36'h0_39CE_739C;
    kick(19'h00100, 19'd1);
    step(); step(); step();
    chk("t1_valid_early", 32'(point_valid), 0);
    step();
    chk("t1_valid_c3", 32'(point_valid), 1);
    chk("t1_x", 32'(point_x), 32'(10'h39C));
    chk("t1_y", 32'(point_y), 32'(10'h39C));
    chk("t1_z", 32'(point_z), 32'(10'h39C));
    step();
    chk("t1_valid_after", 32'(point_valid), 0);
    chk("t1_done_early", 32'(done), 0);
    chk("t1_busy_mid", 32'(busy), 1);
    step();
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_fall", 32'(busy), 0);
    step();
    chk("t1_done_pulse", 32'(done), 0);

    // 5x5x5 grid at full rate
    for (int i = 0; i < 125; i++) mem[i] = {6'h2A, crd(i / 25), crd((i / 5) % 5), crd(i % 5)};
    r0 = rx.size();
    kick(19'd0, 19'd125);
    k = 0;
    while (!point_valid && k < 20) begin step(); k++; end
    for (int i = 0; i < 125; i++) begin
      chk("t2_consecutive", 32'(point_valid), 1);
      step();
    end
    wait_done("t2", 50);
    chk("t2_count", 32'(rx.size() - r0), 125);
    chk("t2_p62", 32'(rx[r0 + 62]), 32'(30'h0));
    chk("t2_p124", 32'(rx[r0 + 124]), 32'({10'h064, 10'h064, 10'h064}));

    // same grid with random backpressure and a long stall
    r0 = rx.size();
    d0 = done_n;
    kick(19'd0, 19'd125);
    k = 0;
    while (done_n == d0 && k < 3000) begin
      @(posedge clk);
      #1;
      if (k == 50) chk("t3_fifo_full", 32'(dut.cnt_q), 4);
      point_ready = (k >= 30 && k < 50) ? 1'b0 : 1'($urandom_range(0, 1));
      k++;
    end
    point_ready = 1'b1;
    chk("t3_done", 32'(done_n != d0), 1);
    step();
    chk("t3_count", 32'(rx.size() - r0), 125);
    chk("t3_empty", 32'(exp_q.size()), 0);

    // address wrap
    wl = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    for (int i = 0; i < 4; i++) mem[wl[i]] = {6'h3F, 30'(i * 30'h1234567 + 30'h0ABC)};
    iss_q.delete();
    r0 = rx.size();
    kick(19'h7FFFE, 19'd4);
    wait_done("t4", 50);
    chk("t4_issues", 32'(iss_q.size()), 4);
    for (int i = 0; i < 4 && i < iss_q.size(); i++) chk("t4_addr", 32'(iss_q[i]), 32'(wl[i]));
    chk("t4_count", 32'(rx.size() - r0), 4);

    // zero-length pass
    iss_q.delete();
    kick(19'h00100, 19'd0);
    step();
    chk("t5_done", 32'(done), 1);
    chk("t5_busy", 32'(busy), 0);
    step();
    chk("t5_done_pulse", 32'(done), 0);
    chk("t5_no_reads", 32'(iss_q.size()), 0);

    // restart ignored while busy
    for (int i = 0; i < 10; i++) mem[19'h200 + 19'(i)] = {6'h01, 30'(i * 30'h0101 + 30'h2222)};
    for (int i = 0; i < 5; i++) mem[19'h300 + 19'(i)] = {6'h02, 30'h3FFF_0000 | 30'(i)};
    iss_q.delete();
    r0 = rx.size();
    kick(19'h200, 19'd10);
    chk("t5_busy_pass", 32'(busy), 1);
    @(posedge clk);
    #1 start = 1'b1; base_addr = 19'h300; num_points = 19'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t5b", 60);
    repeat (10) step();
    chk("t5b_count", 32'(rx.size() - r0), 10);
    chk("t5b_reads", 32'(iss_q.size()), 10);
    chk("t5b_empty", 32'(exp_q.size()), 0);

    // reset mid-pass then a fresh short pass
    for (int i = 0; i < 10; i++) mem[19'h400 + 19'(i)] = {6'h05, 30'(i * 30'h0777 + 30'h1111)};
    for (int i = 0; i < 3; i++) mem[19'h500 + 19'(i)] = {6'h06, 30'(i * 30'h0333 + 30'h2A2A)};
    r0 = rx.size();
    kick(19'h400, 19'd10);
    k = 0;
    while (rx.size() < r0 + 5 && k < 100) begin step(); k++; end
    chk("t6_reach5", 32'(rx.size() - r0), 5);
    reset = 1'b1;
    exp_q.delete();
    d0 = done_n;
    step();
    chk("t6_addr", 32'(ram_addr), 0);
    chk("t6_we", 32'(ram_we), 0);
    chk("t6_xyz", 32'(cur), 0);
    chk("t6_valid", 32'(point_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("t6_no_done", 32'(done_n - d0), 0);
    chk("t6_idle_valid", 32'(point_valid), 0);
    r0 = rx.size();
    kick(19'h500, 19'd3);
    wait_done("t6", 50);
    repeat (5) step();
    chk("t6_count", 32'(rx.size() - r0), 3);
    chk("t6_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
